// File: rtl/bidir_bus_master_if.sv
// Host-side request/response bundle for bidir_bus_master.
// The master modport is the bus-master block; slave is the requesting host.
interface bidir_bus_master_if #(
    parameter int W = 8
);
    logic         Req;
    logic         Rnw;
    logic [W-1:0] WrData;
    logic         Ack;
    logic         Busy;
    logic [W-1:0] RdData;
    logic         Err;

    modport master (input Req, Rnw, WrData, output Ack, Busy, RdData, Err);
    modport slave  (output Req, Rnw, WrData, input Ack, Busy, RdData, Err);
endinterface

// File: rtl/bidir_bus_master.sv
// Initiator of the shared bidirectional register bus: drives writes with a Write strobe,
// turns the bus around for reads. Readback-after-write enabled by BIDIR_BUS_READBACK_VERIFY_EN.
module bidir_bus_master #(
    parameter int W        = 8,
    parameter int TURN_CYC = 1
) (
    input  logic               CK,
    input  logic               Reset,
    bidir_bus_master_if.master hif,
    output logic               Control,
    output logic               Write,
    inout  wire  [W-1:0]       Bus
);

`ifdef BIDIR_BUS_READBACK_VERIFY_EN
    localparam bit VERIFY = 1'b1;
`else
    localparam bit VERIFY = 1'b0;
`endif

    localparam logic [3:0] TURN_LAST = 4'(TURN_CYC - 1);

    typedef enum logic [2:0] {
        IDLE,
        DRIVE,
        WHOLD,
        TURN,
        SAMPLE,
        DONE
    } state_t;

    state_t       state_q, state_d;
    logic [3:0]   turn_q, turn_d;
    logic         rnw_q;
    logic [W-1:0] data_q;

    logic         control_d;
    logic         write_d;
    logic         busy_d;
    logic         ack_d;
    logic         err_d;
    logic         load_rd;

    always_ff @(posedge CK or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            turn_q  <= '0;
        end else begin
            state_q <= state_d;
            turn_q  <= turn_d;
        end
    end

    always_ff @(posedge CK or posedge Reset) begin
        if (Reset) begin
            rnw_q  <= 1'b0;
            data_q <= '0;
        end else if (state_q == IDLE && hif.Req) begin
            rnw_q  <= hif.Rnw;
            data_q <= hif.WrData;
        end
    end

    always_comb begin
        state_d = state_q;
        turn_d  = turn_q;
        case (state_q)
            IDLE:   if (hif.Req) state_d = hif.Rnw ? TURN : DRIVE;
            DRIVE:  state_d = WHOLD;
            WHOLD:  state_d = VERIFY ? TURN : DONE;
            TURN: begin
                if (turn_q == TURN_LAST) begin
                    state_d = SAMPLE;
                    turn_d  = '0;
                end else begin
                    turn_d = turn_q + 4'd1;
                end
            end
            SAMPLE: state_d = DONE;
            DONE:   state_d = IDLE;
            default: begin
                state_d = IDLE;
                turn_d  = '0;
            end
        endcase
    end

    // Outputs are registered from the current state, so the visible phase trails the
    // state register by one cycle: the bus seen while state_q is DONE is the SAMPLE phase.
    always_comb begin
        control_d = (state_q == DRIVE) || (state_q == WHOLD);
        write_d   = (state_q == DRIVE);
        busy_d    = (state_q != IDLE);
        ack_d     = (state_q == DONE);
        load_rd   = (state_q == DONE) && (rnw_q || VERIFY);
        err_d     = VERIFY && (state_q == DONE) && !rnw_q && (Bus != data_q);
    end

    always_ff @(posedge CK or posedge Reset) begin
        if (Reset) begin
            Control    <= 1'b0;
            Write      <= 1'b0;
            hif.Busy   <= 1'b0;
            hif.Ack    <= 1'b0;
            hif.Err    <= 1'b0;
            hif.RdData <= '0;
        end else begin
            Control  <= control_d;
            Write    <= write_d;
            hif.Busy <= busy_d;
            hif.Ack  <= ack_d;
            hif.Err  <= err_d;
            if (load_rd) hif.RdData <= Bus;
        end
    end

    assign Bus = Control ? data_q : {W{1'bz}};

endmodule

// File: tb/tb_bidir_bus_master.sv
// Bench for bidir_bus_master: two instances (TURN_CYC 1 and 3), each with a remote enable-flop
// on its own bus, checked cycle by cycle against transaction-level timing and a register scoreboard.
module tb_bidir_bus_master;

`ifdef BIDIR_BUS_READBACK_VERIFY_EN
    localparam bit VERIFY = 1'b1;
`else
    localparam bit VERIFY = 1'b0;
`endif

    localparam int W = 8;

    logic CK = 1'b0;
    logic Reset;
    always #5 CK = ~CK;

    logic         req[2];
    logic         rnw[2];
    logic [W-1:0] wdat[2];
    logic         ack[2];
    logic         busy[2];
    logic         err[2];
    logic         control[2];
    logic         write[2];
    logic [W-1:0] rddata[2];
    logic [W-1:0] busv[2];
    logic [W-1:0] remote_q[2];
    logic         stuck[2];
    int           ack_cnt[2] = '{0, 0};

    logic [W-1:0] model_reg[2];
    logic [W-1:0] exp_rd[2];

    int checks = 0;
    int errors = 0;

    wire [W-1:0] bus0, bus1;
    logic ctl0, ctl1, wr0, wr1;

    bidir_bus_master_if #(.W(W)) hif0 ();
    bidir_bus_master_if #(.W(W)) hif1 ();

    bidir_bus_master #(.W(W), .TURN_CYC(1)) dut0 (
        .CK(CK), .Reset(Reset), .hif(hif0), .Control(ctl0), .Write(wr0), .Bus(bus0)
    );
    bidir_bus_master #(.W(W), .TURN_CYC(3)) dut1 (
        .CK(CK), .Reset(Reset), .hif(hif1), .Control(ctl1), .Write(wr1), .Bus(bus1)
    );

    assign hif0.Req = req[0];  assign hif0.Rnw = rnw[0];  assign hif0.WrData = wdat[0];
    assign hif1.Req = req[1];  assign hif1.Rnw = rnw[1];  assign hif1.WrData = wdat[1];
    assign ack[0] = hif0.Ack;  assign busy[0] = hif0.Busy;  assign err[0] = hif0.Err;
    assign ack[1] = hif1.Ack;  assign busy[1] = hif1.Busy;  assign err[1] = hif1.Err;
    assign rddata[0] = hif0.RdData;  assign rddata[1] = hif1.RdData;
    assign control[0] = ctl0;  assign control[1] = ctl1;
    assign write[0] = wr0;     assign write[1] = wr1;
    assign busv[0] = bus0;     assign busv[1] = bus1;

    // Remote side: drives its register whenever the master has released the bus.
    assign bus0 = ctl0 ? {W{1'bz}} : remote_q[0];
    assign bus1 = ctl1 ? {W{1'bz}} : remote_q[1];

    always @(posedge CK) begin
        for (int d = 0; d < 2; d++) begin
            if (stuck[d]) remote_q[d] <= '0;
            else if (write[d]) remote_q[d] <= busv[d];
        end
    end

    always @(negedge CK) begin
        for (int d = 0; d < 2; d++)
            if (ack[d] === 1'b1) ack_cnt[d] <= ack_cnt[d] + 1;
    end

    function automatic int tcyc(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    // Caller has set req/rnw/wdat for dut d at #1 after an edge; acceptance is the next edge.
    // Returns #1 into the Ack cycle with req low, so an immediate re-request is back-to-back.
    task automatic txn(input int d, input bit rd, input logic [W-1:0] wd, input bit noise);
        int ackc;
        bit exp_err;
        logic [3:0] got, want;
        ackc = rd ? tcyc(d) + 2 : (VERIFY ? tcyc(d) + 4 : 3);
        exp_err = 1'b0;
        if (rd) begin
            exp_rd[d] = model_reg[d];
        end else begin
            model_reg[d] = stuck[d] ? '0 : wd;
            if (VERIFY) begin
                exp_rd[d] = model_reg[d];
                exp_err   = (model_reg[d] != wd);
            end
        end
        @(posedge CK); #1;
        req[d] = 1'b0;
        for (int c = 0; c <= ackc; c++) begin
            if (c > 0) begin @(posedge CK); #1; end
            got  = {write[d], control[d], busy[d], ack[d]};
            want = {!rd && c == 1, !rd && (c == 1 || c == 2), c >= 1, c == ackc};
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL txn_cycle dut%0d rd=%0b cyc%0d: {Write,Control,Busy,Ack} got %b want %b",
                         d, rd, c, got, want);
            end
            checks++;
            if (err[d] !== ((c == ackc) ? exp_err : 1'b0)) begin
                errors++;
                $display("FAIL err_flag dut%0d cyc%0d: got %b want %b", d, c, err[d],
                         (c == ackc) ? exp_err : 1'b0);
            end
            if (!rd && c == 1) begin
                checks++;
                if (busv[d] !== wd) begin
                    errors++;
                    $display("FAIL bus_drive dut%0d: got %h want %h", d, busv[d], wd);
                end
            end
            if (c == ackc) begin
                checks++;
                if (rddata[d] !== exp_rd[d]) begin
                    errors++;
                    $display("FAIL rddata dut%0d rd=%0b: got %h want %h", d, rd, rddata[d], exp_rd[d]);
                end
            end
            if (noise && c < ackc) begin
                req[d]  = 1'($urandom_range(0, 1));
                rnw[d]  = 1'($urandom_range(0, 1));
                wdat[d] = W'($urandom);
            end
        end
        req[d] = 1'b0;
    endtask

    task automatic issue(input int d, input bit rd, input logic [W-1:0] wd, input bit noise);
        req[d] = 1'b1; rnw[d] = rd; wdat[d] = wd;
        txn(d, rd, wd, noise);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge CK);
        #1;
    endtask

    task automatic test_reset;
        Reset = 1'b1;
        for (int d = 0; d < 2; d++) begin
            req[d] = 1'b0; rnw[d] = 1'b0; wdat[d] = '0; stuck[d] = 1'b1;
            model_reg[d] = '0; exp_rd[d] = '0;
        end
        idle(3);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if ({ack[d], busy[d], err[d], control[d], write[d], rddata[d]} !== '0) begin
                errors++;
                $display("FAIL reset_state dut%0d: Ack=%b Busy=%b Err=%b Control=%b Write=%b RdData=%h want all 0",
                         d, ack[d], busy[d], err[d], control[d], write[d], rddata[d]);
            end
        end
        stuck[0] = 1'b0; stuck[1] = 1'b0;
        Reset = 1'b0;
    endtask

    task automatic test_write_read;
        issue(0, 1'b0, 8'h3C, 1'b0);
        idle(1);
        issue(0, 1'b1, 8'h00, 1'b0);
        idle(1);
    endtask

    task automatic test_turnaround;
        issue(1, 1'b0, 8'hC3, 1'b0);
        idle(2);
        issue(1, 1'b1, 8'h11, 1'b0);
        idle(1);
    endtask

    task automatic test_back_to_back;
        for (int d = 0; d < 2; d++) begin
            int base;
            base = ack_cnt[d];
            for (int i = 0; i < 10; i++)
                issue(d, 1'(i % 2), W'($urandom), 1'b1);
            idle(3);
            checks++;
            if (ack_cnt[d] - base !== 10) begin
                errors++;
                $display("FAIL b2b_ack_count dut%0d: got %0d want 10", d, ack_cnt[d] - base);
            end
        end
    endtask

    task automatic test_verify;
        for (int d = 0; d < 2; d++) begin
            stuck[d] = 1'b1;
            idle(1);
            issue(d, 1'b0, 8'hFF, 1'b0);
            idle(1);
            stuck[d] = 1'b0;
            idle(1);
            issue(d, 1'b0, 8'h5A, 1'b0);
            idle(1);
            issue(d, 1'b1, 8'h00, 1'b0);
            idle(1);
        end
    endtask

    task automatic test_random;
        for (int i = 0; i < 40; i++) begin
            int d;
            d = i % 2;
            issue(d, 1'($urandom_range(0, 1)), W'($urandom), 1'($urandom_range(0, 1)));
            idle($urandom_range(0, 2));
        end
    endtask

    task automatic test_reset_mid;
        issue(0, 1'b0, 8'h77, 1'b0);
        idle(1);
        req[0] = 1'b1; rnw[0] = 1'b0; wdat[0] = 8'h99;
        @(posedge CK); #1;
        req[0] = 1'b0;
        @(posedge CK); #1;
        checks++;
        if ({write[0], control[0]} !== 2'b11) begin
            errors++;
            $display("FAIL mid_drive dut0: {Write,Control} got %b want 11", {write[0], control[0]});
        end
        Reset = 1'b1;
        #1;
        checks++;
        if ({write[0], control[0], ack[0], busy[0], rddata[0]} !== '0) begin
            errors++;
            $display("FAIL async_reset dut0: Write=%b Control=%b Ack=%b Busy=%b RdData=%h want all 0",
                     write[0], control[0], ack[0], busy[0], rddata[0]);
        end
        exp_rd[0] = '0; exp_rd[1] = '0;
        @(posedge CK); #1;
        Reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            checks++;
            if (ack[0] !== 1'b0) begin
                errors++;
                $display("FAIL no_ack_after_reset cyc%0d: got %b want 0", c, ack[0]);
            end
            @(posedge CK); #1;
        end
        issue(0, 1'b1, 8'h00, 1'b0);
        issue(0, 1'b0, 8'hA5, 1'b0);
        issue(0, 1'b1, 8'h00, 1'b0);
        idle(1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_write_read();
        test_turnaround();
        test_back_to_back();
        test_verify();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bidir_bus_master.md
# bidir_bus_master

Initiator end of the shared bidirectional register bus. A host issues word write/read requests. The block owns the direction line `Control` and the write strobe `Write`. For writes it drives the shared tri-state bus and pulses `Write` so the remote enable-flop captures the data. For reads it releases the bus, waits for turnaround, samples the remote register's driven value, and returns it with a one-cycle `Ack`.

## Interface
Parameters:
- `W`, 8: bus and data width in bits.
- `TURN_CYC`, 1: turnaround cycles after the master releases the bus, before sampling. Legal range 1..15.

Ports:
- `CK` input 1: the single clock; all state updates on its rising edge.
- `Reset` input 1: asynchronous, active-high.
- `Req` input 1: transaction request; sampled only in IDLE.
- `Rnw` input 1: 1 = read, 0 = write; latched when `Req` is accepted.
- `WrData` input W: write data; latched when `Req` is accepted.
- `Ack` output 1: one-cycle completion pulse.
- `Busy` output 1: high from the cycle after acceptance up to and including the `Ack` cycle.
- `RdData` output W: last sampled bus value; holds its value between reads.
- `Err` output 1: readback mismatch pulse, coincident with `Ack`. Tied 0 unless the verify feature is compiled in.
- `Control` output 1: 1 = master drives the bus; 0 = remote drives the bus.
- `Write` output 1: enable strobe to the remote register.
- `Bus` inout W: shared data lines. The master drives `Bus` with the latched data when `Control` = 1, and leaves it high-Z otherwise.

## Operation
- All outputs are registered. `Bus` is enabled directly from the registered `Control`.
- FSM states and exits:
  - IDLE: `Req`&!`Rnw` → DRIVE; `Req`&`Rnw` → TURN.
  - DRIVE: → WHOLD.
  - WHOLD: → DONE, or → TURN when verify is compiled in.
  - TURN: counts `TURN_CYC` cycles, then → SAMPLE.
  - SAMPLE: → DONE.
  - DONE: → IDLE.
- Output values by state:
  - IDLE: `Control`=0, `Write`=0, `Busy`=0.
  - DRIVE: `Control`=1, `Write`=1, `Bus`=latched data.
  - WHOLD: `Control`=1, `Write`=0. Holds the data one cycle past the strobe.
  - TURN: `Control`=0, bus released.
  - SAMPLE: `Control`=0. `RdData` is loaded from `Bus` at the edge that ends SAMPLE.
  - DONE: `Ack`=1, `Busy`=1, `Control`=0.
- `Control` and `Write` are never high while the master is released. `Write`=1 implies `Control`=1.
- Host-side rules:
  - `Req` is ignored outside IDLE. No queuing.
  - A `Req` held through DONE is accepted on the first IDLE edge, giving back-to-back transactions.
  - Changes to `WrData`/`Rnw` after acceptance have no effect.
- X or Z sampled on `Bus` is passed through to `RdData` unmodified. No resolution is applied.

## Timing
- Edge 0 is the rising edge that accepts `Req` in IDLE.
- Write (no verify):
  - DRIVE is cycle 1; the remote captures at edge 2.
  - WHOLD is cycle 2.
  - `Ack` is high in cycle 3.
  - Next acceptance is possible at edge 4.
- Read:
  - TURN occupies cycles 1..`TURN_CYC`.
  - SAMPLE is cycle `TURN_CYC`+1.
  - `Ack` and new `RdData` are valid in cycle `TURN_CYC`+2.
- Write with verify: `Ack`, `Err` and readback `RdData` are valid in cycle `TURN_CYC`+4.
- Reset values: `Ack`=0, `Busy`=0, `Err`=0, `RdData`=0, `Control`=0, `Write`=0, `Bus`=Z, FSM=IDLE, turn counter=0.
- Reset asserted mid-transaction:
  - The FSM returns to IDLE immediately.
  - `Write` and `Control` drop asynchronously, without waiting for a clock edge.
  - No `Ack` is issued and `RdData` is cleared.
- After `Reset` deasserts, the first `Req` acceptance is possible at the next rising edge.

## Configuration
- Macro `BIDIR_BUS_READBACK_VERIFY_EN`.
- Defined:
  - Every write continues WHOLD→TURN→SAMPLE→DONE.
  - `RdData` receives the readback value.
  - `Err`=1 in the `Ack` cycle if readback ≠ latched write data, else 0.
- Undefined:
  - Writes end at WHOLD→DONE.
  - `Err` is constant 0.
  - `RdData` is untouched by writes.
- Reads behave identically in both builds.

## Test plan
- Reset: assert `Reset` mid-DRIVE → `Write`/`Control` fall before the next `CK` edge, no `Ack`, `RdData`=0; after release, a write of 8'hA5 completes normally.
- Write then read: with the remote register model, write 8'h3C → `Ack` in cycle 3 with `Write` high only in cycle 1. Then a read with `TURN_CYC`=1 → `Ack` in cycle 3 and `RdData`=8'h3C.
- Turnaround: with `TURN_CYC`=3, a read → `Control`=0 and bus released for cycles 1..3, sample in cycle 4, `Ack` in cycle 5. Check that no cycle has both ends driving.
- Back-to-back: hold `Req` with `Rnw` toggled between 0 and 1 → write and read alternate with no lost requests. `Req` pulses during `Busy` are ignored (`Ack` count equals accepted count).
- Verify build: force the remote to hold 8'h00 against a write of 8'hFF → `Err`=1 with `Ack` in cycle `TURN_CYC`+4 and `RdData`=8'h00. A matching write gives `Err`=0.
- Non-verify build: same forced mismatch → `Ack` in cycle 3, `Err`=0, `RdData` unchanged.
